// File: rtl/sa_psum_drain_pkg.sv
// ----------------------------------------------------------------------------
// sa_psum_drain_pkg : shared FSM encoding and lane helpers        | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sa_psum_drain_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  localparam int DEF_ACC_W = 8;

  function automatic int lane_lo(input int j, input int w);
    return j * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sa_sync_fifo.sv
// ----------------------------------------------------------------------------
// sa_sync_fifo : first-word-fall-through FIFO, head driven from storage regs | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sa_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop     = i_rd_en && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push    = i_wr_en && (!o_full || w_pop);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sa_psum_drain.sv
// ----------------------------------------------------------------------------
// sa_psum_drain : deskews bottom-row psums and emits aligned rows over v/r | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sa_psum_drain
  import sa_psum_drain_pkg::*;
#(
  parameter int N          = 4,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int ROWS_MAX   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic [$clog2(ROWS_MAX+1)-1:0] i_num_rows,
  input  logic                          i_col0_valid,
  input  logic [N*ACC_W-1:0]            i_psum_in,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [N*ACC_W-1:0]            o_out_data,
  output logic                          o_out_last,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_overflow
);

  localparam int NRW = $clog2(ROWS_MAX+1);
  localparam int DW  = N * ACC_W;

  state_t           r_state;
  logic [NRW-1:0]   r_num;
  logic [NRW-1:0]   r_seen;
  logic             r_done;
  logic             r_overflow;
  logic [N-2:0]     r_vld;
  logic [DW-1:0]    w_row;
  logic             w_row_valid;
  logic             w_is_last;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [DW:0]      w_fifo_rd;

  // Column j is late by j cycles; delaying it by N-1-j lines every column up.
  for (genvar j = 0; j < N; j++) begin : g_col
    if (j == N-1) begin : g_pass
      assign w_row[j*ACC_W +: ACC_W] = i_psum_in[j*ACC_W +: ACC_W];
    end else begin : g_dly
      localparam int D = N - 1 - j;
      logic [ACC_W-1:0] r_pipe [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= i_psum_in[lane_lo(j, ACC_W) +: ACC_W];
          for (int k = 1; k < D; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end
      assign w_row[j*ACC_W +: ACC_W] = r_pipe[D-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_col0_valid;
      for (int k = 1; k < N-1; k++) r_vld[k] <= r_vld[k-1];
    end
  end

  assign w_row_valid = r_vld[N-2];
  assign w_is_last   = (r_seen == r_num - NRW'(1));
  assign w_push      = w_row_valid && (r_state == S_CAPTURE);
  assign w_pop       = o_out_valid && i_out_ready;
  assign w_drop      = w_push && w_full && !w_pop;

  sa_sync_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_push),
    .i_wr_data ({w_is_last, w_row}),
    .i_rd_en   (i_out_ready),
    .o_rd_data (w_fifo_rd),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Dropped rows still advance r_seen so a job always reaches DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_num      <= '0;
      r_seen     <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_num_rows != '0) begin
              r_state    <= S_CAPTURE;
              r_num      <= i_num_rows;
              r_seen     <= '0;
              r_overflow <= 1'b0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (w_row_valid) begin
            r_seen <= r_seen + NRW'(1);
            if (w_is_last) r_state <= S_DRAIN;
          end
          if (w_drop) r_overflow <= 1'b1;
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_out_valid = !w_empty;
  assign o_out_data  = w_fifo_rd[DW-1:0];
  assign o_out_last  = w_fifo_rd[DW];
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sa_psum_drain.sv
// ----------------------------------------------------------------------------
// tb_sa_psum_drain : directed scoreboard bench for sa_psum_drain  | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sa_psum_drain;

  localparam int N          = 4;
  localparam int ACC_W      = 8;
  localparam int ROWS_MAX   = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int NRW        = $clog2(ROWS_MAX+1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [NRW-1:0]  num_rows = '0;
  logic            col0_valid = 1'b0;
  logic [31:0]     psum_in = '0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [31:0]     out_data;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            overflow;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;

  logic [32:0] sb[$];
  int          got_cyc[$];
  logic        hold_pend = 1'b0;
  logic [32:0] hold_val  = '0;

  sa_psum_drain #(
    .N          (N),
    .ACC_W      (ACC_W),
    .ROWS_MAX   (ROWS_MAX),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_num_rows   (num_rows),
    .i_col0_valid (col0_valid),
    .i_psum_in    (psum_in),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_out_last   (out_last),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Row k, column j carries 8'h10*(k+1)+j, so row k reads 32'h13121110 + k*32'h10101010.
  task automatic expect_row(input int k, input logic last);
    logic [31:0] v;
    v = 32'h13121110 + 32'(k) * 32'h10101010;
    sb.push_back({last, v});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_beat", 64'({out_last, out_data}), 64'(hold_val));
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_last, out_data};
      if (out_valid && out_ready) begin
        got_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", {out_last, out_data});
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          check("beat_data", 64'(out_data), 64'(e[31:0]));
          check("beat_last", 64'(out_last), 64'(e[32]));
        end
      end
    end
  end

  task automatic do_start(input int nr);
    @(posedge clk); #1;
    start    = 1'b1;
    num_rows = NRW'(nr);
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Drives nrows rows with column j of row k on the bus in relative cycle k+j.
  task automatic stream(input int nrows, input int ready_at, input int start_at);
    for (int c = 0; c < nrows + N - 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) t0 = cyc;
      col0_valid = (c < nrows);
      for (int j = 0; j < N; j++) begin
        int k;
        k = c - j;
        if (k >= 0 && k < nrows) psum_in[j*8 +: 8] = 8'(8'h10 * (k + 1) + j);
        else                     psum_in[j*8 +: 8] = 8'hEE;
      end
      if (ready_at >= 0 && c >= ready_at) out_ready = 1'b1;
      start = (c == start_at);
      if (c == start_at) num_rows = NRW'(1);
    end
    @(posedge clk); #1;
    col0_valid = 1'b0;
    start      = 1'b0;
    psum_in    = '0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done"}, 64'(seen), 64'd1);
    check({name, "_idle"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'd0);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single row, latency from col0_valid to out_valid is N cycles
    out_ready = 1'b1;
    got_cyc.delete();
    expect_row(0, 1'b1);
    do_start(1);
    stream(1, -1, -1);
    wait_done("single");
    check("single_beats", 64'(got_cyc.size()), 64'd1);
    if (got_cyc.size() == 1) check("single_lat", 64'(got_cyc[0] - t0), 64'd4);

    // back-to-back rows, one beat per cycle
    got_cyc.delete();
    expect_row(0, 1'b0);
    expect_row(1, 1'b0);
    expect_row(2, 1'b1);
    do_start(3);
    stream(3, -1, -1);
    wait_done("stream");
    check("stream_beats", 64'(got_cyc.size()), 64'd3);
    for (int k = 0; k < got_cyc.size(); k++) check("stream_lat", 64'(got_cyc[k] - t0), 64'(4 + k));

    // backpressure: rows 4 and 5 are dropped, so no beat carries out_last
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) expect_row(k, 1'b0);
    do_start(6);
    stream(6, -1, -1);
    @(negedge clk);
    check("bp_ovf", 64'(overflow), 64'd1);
    check("bp_busy", 64'(busy), 64'd1);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_head", 64'(out_data), 64'h13121110);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("bp");
    check("bp_ovf_sticky", 64'(overflow), 64'd1);

    // zero-row job: done next cycle, overflow untouched
    do_start(0);
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_ovf", 64'(overflow), 64'd1);
    @(negedge clk);
    check("zero_done_pulse", 64'(done), 64'd0);

    // full FIFO with push and pop in the same cycle
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) expect_row(k, 1'b0);
    expect_row(4, 1'b1);
    do_start(5);
    stream(5, 7, -1);
    wait_done("full");
    check("full_ovf", 64'(overflow), 64'd0);

    // start pulsed while capturing must not reload the row count
    out_ready = 1'b1;
    expect_row(0, 1'b0);
    expect_row(1, 1'b1);
    do_start(2);
    stream(2, -1, 1);
    wait_done("restart");

    // asynchronous reset in the middle of a backpressured job
    out_ready = 1'b0;
    do_start(6);
    stream(6, -1, -1);
    @(negedge clk);
    check("mid_pre_ovf", 64'(overflow), 64'd1);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // recovery after reset
    out_ready = 1'b1;
    expect_row(0, 1'b1);
    do_start(1);
    stream(1, -1, -1);
    wait_done("recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
